// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin bus arbiter with registered grant and optional tenure watchdog.
//
// Only one requester holds the bus at a time. Each release is followed by one IDLE cycle
// before the next grant. The next search starts just above the requester that was released.
//
// Optional feature (compile-time macro ARB_TIMEOUT_EN):
//   When the macro is defined, a tenure counter limits each grant to TIMEOUT cycles.
//   A forced release raises timeout_err for the one IDLE cycle that follows it.
//   When the macro is undefined, there is no counter and timeout_err is tied low.
//
// Parameters:
//   NUM_REQ  number of requesters (2..16)
//   IDX_W    grant index width, must equal $clog2(NUM_REQ)
//   TIMEOUT  maximum grant tenure in cycles (1..255), used only with ARB_TIMEOUT_EN
//
// Ports:
//   clk          clock, rising-edge active
//   rst_n        asynchronous active-low reset
//   req          per-requester level request, bit i = requester i
//   done         release strobe from the current grant holder
//   grant_valid  high while a grant is held
//   grant_idx    binary index of the grant holder, 0 when no grant
//   grant_oh     one-hot form of grant_idx when valid, all zero otherwise
//   timeout_err  one-cycle pulse after a watchdog-forced release
module bus_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic               timeout_err
);

    if (NUM_REQ < 2 || NUM_REQ > 16 || IDX_W != $clog2(NUM_REQ) ||
        TIMEOUT < 1 || TIMEOUT > 255) begin : gen_param_check
        $error("bus_arbiter: illegal parameter combination");
    end

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic               rel;
    logic               expire;

`ifdef ARB_TIMEOUT_EN
    // The release fires on the edge where the counter would reach TIMEOUT.
    // As a result, the grant is visible for exactly TIMEOUT cycles.
    localparam logic [7:0] TenureLast = 8'(TIMEOUT - 1);

    logic [7:0] tenure_q, tenure_d;
    logic       err_q, err_d;

    assign expire      = (tenure_q == TenureLast);
    assign timeout_err = err_q;
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Rotating priority search.
    // Scan upward from ptr and wrap to 0; the first set req bit wins.
    always_comb begin
        int unsigned pos;
        pos       = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pos = (32'(ptr_q) + i) % NUM_REQ;
            if (!sel_found && req[pos]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(pos);
            end
        end
    end

    // Release takes priority over any new request that arrives in the same cycle.
    assign rel = done || !req[idx_q];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
`ifdef ARB_TIMEOUT_EN
        tenure_d = tenure_q;
        err_d    = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
`ifdef ARB_TIMEOUT_EN
                tenure_d = '0;
`endif
                if (sel_found) begin
                    state_d = StGrant;
                    idx_d   = sel_idx;
                end
            end
            StGrant: begin
                if (rel || expire) begin
                    state_d = StIdle;
                    idx_d   = '0;
                    ptr_d   = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
`ifdef ARB_TIMEOUT_EN
                    err_d   = expire && !rel;
`endif
                end else begin
`ifdef ARB_TIMEOUT_EN
                    tenure_d = tenure_q + 8'd1;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            idx_q   <= '0;
`ifdef ARB_TIMEOUT_EN
            tenure_q <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
`ifdef ARB_TIMEOUT_EN
            tenure_q <= tenure_d;
            err_q    <= err_d;
`endif
        end
    end

    // Outputs are decoded straight from flops.
    // This lets an asynchronous reset clear them without waiting for a clock edge.
    assign grant_valid = (state_q == StGrant);
    assign grant_idx   = idx_q;

    always_comb begin
        grant_oh = '0;
        if (state_q == StGrant) begin
            grant_oh[idx_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: self-checking bench for bus_arbiter.
// Expected grant indices are queued when stimulus is applied.
// Each one is popped and compared when the DUT raises its grant.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_bus_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned TIMEOUT = 4;

    logic               clk;
    logic               rst_n;
    logic [NUM_REQ-1:0] req;
    logic               done;
    logic               grant_valid;
    logic [IDX_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] grant_oh;
    logic               timeout_err;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int exp_idx;
    logic [NUM_REQ-1:0] exp_oh;

    bus_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .grant_oh    (grant_oh),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic pop_exp();
        if (exp_q.size() == 0) begin
            exp_idx = -1;
            exp_oh  = '0;
        end else begin
            exp_idx = exp_q.pop_front();
            exp_oh  = '0;
            exp_oh[exp_idx] = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        req   = '1;
        done  = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({grant_valid, grant_idx, grant_oh, timeout_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b idx=%0d oh=%b err=%b, required all 0",
                     grant_valid, grant_idx, grant_oh, timeout_err);
        end
        req   = '0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (grant_valid !== 1'b0 || grant_oh !== '0) begin
            errors++;
            $display("FAIL idle_no_req: valid=%b oh=%b, required 0 and 0000", grant_valid, grant_oh);
        end
    endtask

    task automatic test_single();
        req = 4'b0100;
        exp_q.push_back(2);
        @(negedge clk);
        pop_exp();
        checks++;
        if (grant_valid !== 1'b1 || grant_idx !== IDX_W'(exp_idx) || grant_oh !== exp_oh) begin
            errors++;
            $display("FAIL single_grant: valid=%b idx=%0d oh=%b, required 1 %0d %b",
                     grant_valid, grant_idx, grant_oh, exp_idx, exp_oh);
        end
        done = 1'b1;
        @(negedge clk);
        checks++;
        if (grant_valid !== 1'b0 || grant_idx !== '0 || grant_oh !== '0) begin
            errors++;
            $display("FAIL done_release: valid=%b idx=%0d oh=%b, required 0 0 0000",
                     grant_valid, grant_idx, grant_oh);
        end
        // The pointer must now be 3. Requesters 2 and 3 both ask; requester 3 should win.
        done = 1'b0;
        req  = 4'b1100;
        exp_q.push_back(3);
        @(negedge clk);
        pop_exp();
        checks++;
        if (grant_valid !== 1'b1 || grant_idx !== IDX_W'(exp_idx) || grant_oh !== exp_oh) begin
            errors++;
            $display("FAIL ptr_after_done: valid=%b idx=%0d oh=%b, required 1 %0d %b",
                     grant_valid, grant_idx, grant_oh, exp_idx, exp_oh);
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        req = 4'b1111;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        exp_q.push_back(0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            pop_exp();
            checks++;
            if (grant_valid !== 1'b1 || grant_idx !== IDX_W'(exp_idx) || grant_oh !== exp_oh ||
                $countones(grant_oh) != 1) begin
                errors++;
                $display("FAIL round_robin[%0d]: valid=%b idx=%0d oh=%b, required 1 %0d %b",
                         k, grant_valid, grant_idx, grant_oh, exp_idx, exp_oh);
            end
            done = 1'b1;
            @(negedge clk);
            checks++;
            if (grant_valid !== 1'b0) begin
                errors++;
                $display("FAIL rr_idle_gap[%0d]: valid=%b, required 0", k, grant_valid);
            end
            done = 1'b0;
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        req = 4'b1000;
        exp_q.push_back(3);
        @(negedge clk);
        pop_exp();
        checks++;
        if (grant_valid !== 1'b1 || grant_idx !== IDX_W'(exp_idx) || grant_oh !== exp_oh) begin
            errors++;
            $display("FAIL grant_to_3: valid=%b idx=%0d oh=%b, required 1 %0d %b",
                     grant_valid, grant_idx, grant_oh, exp_idx, exp_oh);
        end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        req  = 4'b1001;
        exp_q.push_back(0);
        @(negedge clk);
        pop_exp();
        checks++;
        if (grant_valid !== 1'b1 || grant_idx !== IDX_W'(exp_idx) || grant_oh !== exp_oh) begin
            errors++;
            $display("FAIL wrap_to_0: valid=%b idx=%0d oh=%b, required 1 %0d %b",
                     grant_valid, grant_idx, grant_oh, exp_idx, exp_oh);
        end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        req  = '0;
        @(negedge clk);
    endtask

    task automatic test_req_drop();
        logic [NUM_REQ-1:0] noise [3];
        noise[0] = 4'b1111;
        noise[1] = 4'b1010;
        noise[2] = 4'b0011;
        req = 4'b0010;
        exp_q.push_back(1);
        @(negedge clk);
        pop_exp();
        checks++;
        if (grant_valid !== 1'b1 || grant_idx !== IDX_W'(exp_idx) || grant_oh !== exp_oh) begin
            errors++;
            $display("FAIL grant_to_1: valid=%b idx=%0d oh=%b, required 1 %0d %b",
                     grant_valid, grant_idx, grant_oh, exp_idx, exp_oh);
        end
        for (int k = 0; k < 3; k++) begin
            req = noise[k];
            @(negedge clk);
            checks++;
            if (grant_valid !== 1'b1 || grant_idx !== 2'd1 || grant_oh !== 4'b0010) begin
                errors++;
                $display("FAIL hold_stable[%0d]: valid=%b idx=%0d oh=%b, required 1 1 0010",
                         k, grant_valid, grant_idx, grant_oh);
            end
        end
        req = 4'b0000;
        @(negedge clk);
        checks++;
        if (grant_valid !== 1'b0 || grant_oh !== '0) begin
            errors++;
            $display("FAIL req_drop_release: valid=%b oh=%b, required 0 0000", grant_valid, grant_oh);
        end
    endtask

    task automatic test_back_to_back();
        // The pointer is 2. Only requester 0 asks, so the search wraps to 0.
        req = 4'b0001;
        exp_q.push_back(0);
        @(negedge clk);
        pop_exp();
        checks++;
        if (grant_valid !== 1'b1 || grant_idx !== IDX_W'(exp_idx) || grant_oh !== exp_oh) begin
            errors++;
            $display("FAIL b2b_first: valid=%b idx=%0d oh=%b, required 1 %0d %b",
                     grant_valid, grant_idx, grant_oh, exp_idx, exp_oh);
        end
        done = 1'b1;
        req  = 4'b0011;
        @(negedge clk);
        checks++;
        if (grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_gap: valid=%b, required 0", grant_valid);
        end
        done = 1'b0;
        exp_q.push_back(1);
        @(negedge clk);
        pop_exp();
        checks++;
        if (grant_valid !== 1'b1 || grant_idx !== IDX_W'(exp_idx) || grant_oh !== exp_oh) begin
            errors++;
            $display("FAIL b2b_updated_ptr: valid=%b idx=%0d oh=%b, required 1 %0d %b",
                     grant_valid, grant_idx, grant_oh, exp_idx, exp_oh);
        end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        req  = '0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        req = 4'b0100;
        exp_q.push_back(2);
        @(negedge clk);
        pop_exp();
        checks++;
        if (grant_valid !== 1'b1 || grant_idx !== IDX_W'(exp_idx) || grant_oh !== exp_oh) begin
            errors++;
            $display("FAIL pre_reset_grant: valid=%b idx=%0d oh=%b, required 1 %0d %b",
                     grant_valid, grant_idx, grant_oh, exp_idx, exp_oh);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (grant_valid !== 1'b0 || grant_oh !== '0 || grant_idx !== '0) begin
            errors++;
            $display("FAIL async_reset_drop: valid=%b idx=%0d oh=%b, required 0 0 0000",
                     grant_valid, grant_idx, grant_oh);
        end
        req = 4'b0110;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(1);
        @(negedge clk);
        pop_exp();
        checks++;
        if (grant_valid !== 1'b1 || grant_idx !== IDX_W'(exp_idx) || grant_oh !== exp_oh) begin
            errors++;
            $display("FAIL post_reset_from_0: valid=%b idx=%0d oh=%b, required 1 %0d %b",
                     grant_valid, grant_idx, grant_oh, exp_idx, exp_oh);
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        req = 4'b0010;
        exp_q.push_back(1);
        @(negedge clk);
        pop_exp();
        checks++;
        if (grant_valid !== 1'b1 || grant_idx !== IDX_W'(exp_idx) || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL tenure_start: valid=%b idx=%0d err=%b, required 1 %0d 0",
                     grant_valid, grant_idx, timeout_err, exp_idx);
        end
`ifdef ARB_TIMEOUT_EN
        for (int k = 1; k < int'(TIMEOUT); k++) begin
            @(negedge clk);
            checks++;
            if (grant_valid !== 1'b1 || timeout_err !== 1'b0) begin
                errors++;
                $display("FAIL tenure_hold[%0d]: valid=%b err=%b, required 1 0",
                         k, grant_valid, timeout_err);
            end
        end
        @(negedge clk);
        checks++;
        if (grant_valid !== 1'b0 || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_release: valid=%b err=%b, required 0 1", grant_valid, timeout_err);
        end
        exp_q.push_back(1);
        @(negedge clk);
        pop_exp();
        checks++;
        if (grant_valid !== 1'b1 || grant_idx !== IDX_W'(exp_idx) || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_regrant: valid=%b idx=%0d err=%b, required 1 %0d 0",
                     grant_valid, grant_idx, timeout_err, exp_idx);
        end
`else
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (grant_valid !== 1'b1 || grant_idx !== 2'd1 || timeout_err !== 1'b0) begin
                errors++;
                $display("FAIL unbounded_tenure[%0d]: valid=%b idx=%0d err=%b, required 1 1 0",
                         k, grant_valid, grant_idx, timeout_err);
            end
        end
`endif
        req = '0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_req_drop();
        test_back_to_back();
        test_async_reset();
        test_timeout();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
